// File: rtl/uart_frame_bridge.sv
// UART byte stream <-> block core bridge: command parsing, key/data frame assembly,
// core valid/ready handshake, result serialisation, ack/error replies, timeout and overrun.
module uart_frame_bridge #(
   parameter int         KEY_BYTES      = 16,
   parameter int         IN_BYTES       = 16,
   parameter int         OUT_BYTES      = 16,
   parameter int         TIMEOUT_CYCLES = 1200000,
   parameter logic [7:0] CMD_KEY        = 8'h4B,
   parameter logic [7:0] CMD_DATA       = 8'h44,
   parameter logic [7:0] ACK_BYTE       = 8'hAC,
   parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx_ready,
   input  logic [7:0]             uart_data_from_rx,
   input  logic                   uart_tx_ready,
   output logic                   uart_tx_enable,
   output logic [7:0]             uart_data_to_tx,
   output logic [8*KEY_BYTES-1:0] key_out,
   output logic                   key_valid,
   output logic [8*IN_BYTES-1:0]  blk_data,
   output logic                   blk_valid,
   input  logic                   blk_ready,
   input  logic [8*OUT_BYTES-1:0] res_data,
   input  logic                   res_valid,
   output logic                   res_ready,
   output logic                   busy,
   output logic                   frame_err,
   output logic                   rx_overrun
);

   localparam int KW        = 8 * KEY_BYTES;
   localparam int IW        = 8 * IN_BYTES;
   localparam int OW        = 8 * OUT_BYTES;
   localparam int MAX_KI    = (KEY_BYTES > IN_BYTES) ? KEY_BYTES : IN_BYTES;
   localparam int MAX_BYTES = (MAX_KI > OUT_BYTES) ? MAX_KI : OUT_BYTES;
   localparam int CW        = $clog2(MAX_BYTES + 1);
   localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
   localparam logic [CW-1:0] IN_LAST  = CW'(IN_BYTES - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      IDLE, RX_KEY, RX_DATA, CORE_REQ, CORE_WAIT, TX_RES, TX_ACK, TX_ERR
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] byte_cnt, byte_cnt_next;
   logic [TW-1:0] to_cnt, to_cnt_next;
   logic [KW-1:0] key_sr, key_next;
   logic [OW-1:0] tx_shift;
   logic          tx_wait, tx_go, tx_fire;
   logic [7:0]    tx_byte;
   logic          key_shift, key_done, blk_shift, res_load, res_shift, err_pulse, ovr_pulse;

   // A new byte may go out only after the transmitter has visibly taken the previous one.
   assign tx_go     = uart_tx_ready && !tx_wait;
   assign key_next  = (key_sr << 8) | KW'(uart_data_from_rx);
   assign blk_valid = (state == CORE_REQ);
   assign res_ready = (state == CORE_WAIT);
   assign busy      = (state != IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      byte_cnt_next = byte_cnt;
      to_cnt_next   = to_cnt;
      tx_fire       = 1'b0;
      tx_byte       = '0;
      key_shift     = 1'b0;
      key_done      = 1'b0;
      blk_shift     = 1'b0;
      res_load      = 1'b0;
      res_shift     = 1'b0;
      err_pulse     = 1'b0;
      ovr_pulse     = 1'b0;

      case (state)
         IDLE: begin
            if (uart_rx_ready) begin
               byte_cnt_next = '0;
               to_cnt_next   = '0;
               if (uart_data_from_rx == CMD_KEY)       state_next = RX_KEY;
               else if (uart_data_from_rx == CMD_DATA) state_next = RX_DATA;
               else begin
                  state_next = TX_ERR;
                  err_pulse  = 1'b1;
               end
            end
         end
         RX_KEY, RX_DATA: begin
            if (uart_rx_ready) begin
               to_cnt_next = '0;
               key_shift   = (state == RX_KEY);
               blk_shift   = (state == RX_DATA);
               if (byte_cnt == ((state == RX_KEY) ? KEY_LAST : IN_LAST)) begin
                  byte_cnt_next = '0;
                  key_done      = (state == RX_KEY);
                  state_next    = (state == RX_KEY) ? TX_ACK : CORE_REQ;
               end else begin
                  byte_cnt_next = byte_cnt + CW'(1);
               end
            end else if (TIMEOUT_CYCLES > 0) begin
               if (to_cnt == TO_LAST) begin
                  to_cnt_next   = '0;
                  byte_cnt_next = '0;
                  err_pulse     = 1'b1;
                  state_next    = TX_ERR;
               end else begin
                  to_cnt_next = to_cnt + TW'(1);
               end
            end
         end
         CORE_REQ: begin
            if (blk_ready) state_next = CORE_WAIT;
         end
         CORE_WAIT: begin
            if (res_valid) begin
               res_load = 1'b1;
               // The first result byte leaves straight from the handshake cycle.
               if (tx_go) begin
                  tx_fire       = 1'b1;
                  tx_byte       = res_data[OW-1 -: 8];
                  byte_cnt_next = (OUT_BYTES == 1) ? '0 : CW'(1);
                  state_next    = (OUT_BYTES == 1) ? IDLE : TX_RES;
               end else begin
                  byte_cnt_next = '0;
                  state_next    = TX_RES;
               end
            end
         end
         TX_RES: begin
            if (tx_go) begin
               tx_fire   = 1'b1;
               tx_byte   = tx_shift[OW-1 -: 8];
               res_shift = 1'b1;
               if (byte_cnt == OUT_LAST) begin
                  byte_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  byte_cnt_next = byte_cnt + CW'(1);
               end
            end
         end
         TX_ACK, TX_ERR: begin
            if (tx_go) begin
               tx_fire    = 1'b1;
               tx_byte    = (state == TX_ACK) ? ACK_BYTE : ERR_BYTE;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (uart_rx_ready && (state inside {CORE_REQ, CORE_WAIT, TX_RES, TX_ACK, TX_ERR}))
         ovr_pulse = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         byte_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         state    <= state_next;
         byte_cnt <= byte_cnt_next;
         to_cnt   <= to_cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_sr          <= '0;
         key_out         <= '0;
         key_valid       <= 1'b0;
         blk_data        <= '0;
         tx_shift        <= '0;
         uart_data_to_tx <= '0;
         uart_tx_enable  <= 1'b0;
         tx_wait         <= 1'b0;
         frame_err       <= 1'b0;
         rx_overrun      <= 1'b0;
      end else begin
         key_valid      <= key_done;
         frame_err      <= err_pulse;
         rx_overrun     <= ovr_pulse;
         uart_tx_enable <= tx_fire;
         if (key_shift) key_sr  <= key_next;
         if (key_done)  key_out <= key_next;
         if (blk_shift) blk_data <= (blk_data << 8) | IW'(uart_data_from_rx);
         if (res_load)       tx_shift <= tx_fire ? (res_data << 8) : res_data;
         else if (res_shift) tx_shift <= tx_shift << 8;
         if (tx_fire) begin
            uart_data_to_tx <= tx_byte;
            tx_wait         <= 1'b1;
         end else if (!uart_tx_ready) begin
            tx_wait <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Directed bench for uart_frame_bridge: UART transmitter model, loopback core model,
// hand-computed expected frames and replies.
module tb_uart_frame_bridge;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         uart_rx_ready = 1'b0;
   logic [7:0]   uart_data_from_rx = '0;
   logic         uart_tx_ready = 1'b1;
   logic         uart_tx_enable;
   logic [7:0]   uart_data_to_tx;
   logic [127:0] key_out;
   logic         key_valid;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready = 1'b1;
   logic [127:0] res_data = '0;
   logic         res_valid = 1'b0;
   logic         res_ready;
   logic         busy, frame_err, rx_overrun;

   int n_cmp = 0;
   int n_mis = 0;

   int         cyc = 0;
   logic [7:0] tx_q[$];
   int         en_viol = 0, kv_cnt = 0, fe_cnt = 0, ovr_cnt = 0;
   int         fe_cyc = 0, first_en_cyc = -1, hs_cyc = 0, rx_cyc = 0;
   int         rdy_cnt = 0;
   int         core_delay = 0, core_cnt = 0;
   bit         core_busy = 0, res_taken = 0;
   logic [127:0] core_buf = '0;

   always #5 clk = ~clk;

   uart_frame_bridge #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst),
      .uart_rx_ready(uart_rx_ready), .uart_data_from_rx(uart_data_from_rx),
      .uart_tx_ready(uart_tx_ready), .uart_tx_enable(uart_tx_enable),
      .uart_data_to_tx(uart_data_to_tx),
      .key_out(key_out), .key_valid(key_valid),
      .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .frame_err(frame_err), .rx_overrun(rx_overrun)
   );

   // Handshakes complete on the rising edge; observe them there, drive on the falling edge.
   always @(posedge clk) begin
      if (blk_valid && blk_ready) begin
         core_buf  = blk_data;
         core_cnt  = core_delay;
         core_busy = 1;
      end
      if (res_valid && res_ready) begin
         res_taken = 1;
         hs_cyc    = cyc;
      end
      if (uart_rx_ready) rx_cyc = cyc;
   end

   always @(negedge clk) begin
      cyc++;
      if (key_valid)  kv_cnt++;
      if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (rx_overrun) ovr_cnt++;
      if (uart_tx_enable) begin
         if (!uart_tx_ready) en_viol++;
         if (first_en_cyc < 0) first_en_cyc = cyc;
         tx_q.push_back(uart_data_to_tx);
         uart_tx_ready = 1'b0;
         rdy_cnt       = 3;
      end else if (rdy_cnt > 0) begin
         rdy_cnt--;
         if (rdy_cnt == 0) uart_tx_ready = 1'b1;
      end
      if (res_taken) begin
         res_valid = 1'b0;
         res_taken = 0;
      end
      if (core_busy) begin
         if (core_cnt == 0) begin
            res_data  = core_buf;
            res_valid = 1'b1;
            core_busy = 0;
         end else begin
            core_cnt--;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      #1;
      tx_q.delete();
      en_viol = 0; kv_cnt = 0; fe_cnt = 0; ovr_cnt = 0; first_en_cyc = -1;
   endtask

   // Two idle cycles, then a one-cycle rx pulse; returns on the falling edge after it was consumed.
   task automatic send_byte(input logic [7:0] b);
      repeat (2) @(negedge clk);
      uart_rx_ready     = 1'b1;
      uart_data_from_rx = b;
      @(negedge clk);
      uart_rx_ready     = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] base);
      send_byte(cmd);
      for (int i = 0; i < 16; i++) send_byte(base + 8'(i));
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (tx_q.size() < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("tx_count", 128'(tx_q.size()), 128'(n));
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (6) @(negedge clk);
      check("idle", busy, 0);
   endtask

   function automatic logic [127:0] pack_tx();
      logic [127:0] v = '0;
      for (int i = 0; i < tx_q.size() && i < 16; i++) v = {v[119:0], tx_q[i]};
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctrl", {busy, blk_valid, res_ready, uart_tx_enable, key_valid, frame_err, rx_overrun}, '0);
      check("rst_key", key_out, '0);
      check("rst_blk", blk_data, '0);
      check("rst_txd", uart_data_to_tx, '0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Key load
      clear_stats();
      send_frame(8'h4B, 8'h00);
      wait_tx(1);
      wait_idle();
      check("key_val", key_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("key_vpulse", kv_cnt, 1);
      check("key_ack", tx_q[0], 8'hAC);

      // Data path, blk_ready tied high, immediate loopback core
      clear_stats();
      core_delay = 0;
      blk_ready  = 1'b1;
      send_frame(8'h44, 8'h11);
      check("blk_lat", blk_valid, 1);
      wait_tx(16);
      wait_idle();
      check("dp_blk", blk_data, 128'h1112131415161718191A1B1C1D1E1F20);
      check("dp_tx", pack_tx(), 128'h1112131415161718191A1B1C1D1E1F20);
      check("dp_viol", en_viol, 0);
      check("dp_lat", 128'(first_en_cyc - hs_cyc), 1);
      check("dp_ferr", fe_cnt, 0);

      // Backpressure: core stalls 50 cycles, result 30 cycles late
      begin
         int bad = 0;
         clear_stats();
         core_delay = 30;
         blk_ready  = 1'b0;
         send_frame(8'h44, 8'hA0);
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!blk_valid || blk_data !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) bad++;
            if (tx_q.size() != 0) bad++;
         end
         check("bp_stable", bad, 0);
         blk_ready = 1'b1;
         repeat (25) @(negedge clk);
         check("bp_no_tx", 128'(tx_q.size()), 0);
         check("bp_wait", res_ready, 1);
         wait_tx(16);
         wait_idle();
         check("bp_tx", pack_tx(), 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
         check("bp_viol", en_viol, 0);
         core_delay = 0;
      end

      // Unknown command
      clear_stats();
      send_byte(8'h5A);
      wait_tx(1);
      wait_idle();
      check("unk_ferr", fe_cnt, 1);
      check("unk_err", tx_q[0], 8'hEE);
      check("unk_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);

      // Timeout after a partial data frame, then a clean key frame
      begin
         int k = 0;
         clear_stats();
         send_byte(8'h44);
         for (int i = 0; i < 5; i++) send_byte(8'h70 + 8'(i));
         while (fe_cnt == 0 && k < 300) begin
            @(negedge clk);
            k++;
         end
         check("to_ferr", fe_cnt, 1);
         // 100 idle edges after the last byte, pulse seen on the next falling edge
         check("to_time", 128'(fe_cyc - rx_cyc), 101);
         wait_tx(1);
         wait_idle();
         check("to_err", tx_q[0], 8'hEE);
         clear_stats();
         send_frame(8'h4B, 8'hF0);
         wait_tx(1);
         wait_idle();
         check("to_key", key_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
         check("to_ack", tx_q[0], 8'hAC);
      end

      // Overrun: a byte during result transmission is dropped
      clear_stats();
      send_frame(8'h44, 8'h50);
      wait_tx(3);
      send_byte(8'h4B);
      wait_tx(16);
      wait_idle();
      check("ovr_cnt", ovr_cnt, 1);
      check("ovr_tx", pack_tx(), 128'h505152535455565758595A5B5C5D5E5F);
      check("ovr_txn", 128'(tx_q.size()), 16);

      // Asynchronous reset in the middle of a data frame
      clear_stats();
      send_byte(8'h44);
      for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i));
      #2 rst = 1'b0;
      #1;
      check("ar_ctrl", {busy, blk_valid, res_ready, uart_tx_enable, key_valid, frame_err, rx_overrun}, '0);
      check("ar_key", key_out, '0);
      check("ar_blk", blk_data, '0);
      @(negedge clk);
      rst = 1'b1;
      clear_stats();
      send_frame(8'h4B, 8'h60);
      wait_tx(1);
      wait_idle();
      check("ar_newkey", key_out, 128'h606162636465666768696A6B6C6D6E6F);
      check("ar_ack", tx_q[0], 8'hAC);
      check("ar_txn", 128'(tx_q.size()), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_frame_bridge.md
Name: uart_frame_bridge

Overview:
Parametrised UART-to-block-core framing bridge. It is the generalised successor to the fixed UART/AES byte glue. It sits between the uart byte interface (rx ready/data, tx ready/enable/data) and any block core (AES or other).
- Parses a command byte, assembles key or data frames of configurable width, and hands blocks to the core over valid/ready.
- Serialises the core result back over UART.
- Adds an inter-byte timeout, ack/error reply bytes, and rx overrun detection.

Parameters:
KEY_BYTES, 16, key frame length in bytes (>=1)
IN_BYTES, 16, data block length sent to core (>=1)
OUT_BYTES, 16, result block length returned by core (>=1)
TIMEOUT_CYCLES, 1200000, max clk cycles between bytes of one frame; 0 disables timeout
CMD_KEY, 8'h4B, command byte: load key
CMD_DATA, 8'h44, command byte: process data block
ACK_BYTE, 8'hAC, reply after key load
ERR_BYTE, 8'hEE, reply after unknown command or timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
uart_rx_ready  in  1  one-cycle pulse: uart_data_from_rx valid
uart_data_from_rx  in  8  received byte
uart_tx_ready  in  1  high = UART transmitter idle, can accept byte
uart_tx_enable  out  1  one-cycle pulse: load uart_data_to_tx
uart_data_to_tx  out  8  byte to transmit, held stable until next enable
key_out  out  8*KEY_BYTES  registered key, first received byte in MSB
key_valid  out  1  one-cycle pulse when key_out updated
blk_data  out  8*IN_BYTES  data block, first received byte in MSB
blk_valid  out  1  block offered to core
blk_ready  in  1  core accepts block when blk_valid&blk_ready
res_data  in  8*OUT_BYTES  core result, MSB byte transmitted first
res_valid  in  1  result offered by core
res_ready  out  1  bridge captures res_data when res_valid&res_ready
busy  out  1  high in any state other than IDLE
frame_err  out  1  one-cycle pulse on unknown command or timeout
rx_overrun  out  1  one-cycle pulse when a byte arrives in a non-receiving state

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; key_out, blk_data, uart_data_to_tx, byte counters and timeout counter cleared.
- A reset mid-frame or mid-transmit aborts with no reply. Any in-flight core handshake is dropped.
- States and transitions:
  - IDLE: on rx byte: CMD_KEY -> RX_KEY; CMD_DATA -> RX_DATA; other -> TX_ERR with frame_err pulse.
  - RX_KEY: shift bytes in, MSB-first. On the KEY_BYTES-th byte: update key_out and pulse key_valid in the same cycle as the final register write; next state TX_ACK.
  - RX_DATA: as RX_KEY but into blk_data with IN_BYTES bytes; next state CORE_REQ.
  - CORE_REQ: blk_valid=1 and blk_data held stable. On blk_ready=1 -> CORE_WAIT, with blk_valid dropped the next cycle.
  - CORE_WAIT: res_ready=1. On res_valid=1, capture res_data into the tx shift register -> TX_RES.
  - TX_RES: send OUT_BYTES bytes, MSB byte first -> IDLE after the last byte.
  - TX_ACK: send ACK_BYTE -> IDLE.
  - TX_ERR: send ERR_BYTE -> IDLE.
- TX handshake:
  - A byte is issued by setting uart_data_to_tx and pulsing uart_tx_enable for 1 cycle, only while uart_tx_ready=1.
  - After a pulse, the next byte is not issued until uart_tx_ready has been sampled low and then high again.
- Timeout:
  - In RX_KEY or RX_DATA, the counter resets on each rx byte and increments otherwise.
  - Reaching TIMEOUT_CYCLES discards the partial frame, pulses frame_err, and goes to TX_ERR.
  - The timeout is not applied in IDLE, CORE_* or TX_* states.
  - An rx byte in the same cycle the counter would hit the limit counts as the byte; no timeout.
- Overrun:
  - A uart_rx_ready pulse in CORE_REQ, CORE_WAIT or any TX_* state is dropped and rx_overrun is pulsed.
  - State and data are unaffected.
- Width rules:
  - Byte counters are $clog2(max(KEY_BYTES,IN_BYTES,OUT_BYTES)+1) bits and never wrap.
  - The final-byte compare uses equality to the length minus 1 before the increment.
- Latency:
  - Final rx byte to blk_valid: 1 cycle.
  - res_valid&res_ready to first uart_tx_enable: 1 cycle (if uart_tx_ready=1).
- Simultaneous events:
  - blk_ready may already be high on blk_valid rise; the handshake completes in that cycle.
  - res_valid may be asserted early; it is ignored until CORE_WAIT.

Test Plan:
- Key load: rx 4B then bytes 00..0F -> key_out=0x000102...0F, key_valid pulse exactly once, one tx byte 0xAC, busy returns 0.
- Data path: rx 44 then 16 bytes 0x11..0x20 with blk_ready tied 1 and loopback core (res=blk) -> blk_data=0x1112...20, tx sequence 11,12,...,20, each enable pulse only while uart_tx_ready=1.
- Backpressure: hold blk_ready=0 for 50 cycles, then res_valid delayed 30 cycles -> blk_valid and blk_data stable throughout, no tx until result; correct 16-byte reply.
- Unknown command: rx 0x5A -> frame_err pulse, single tx byte 0xEE, key_out unchanged.
- Timeout: TIMEOUT_CYCLES=100, rx 44 then 5 bytes then silence -> frame_err after 100 idle cycles, tx 0xEE. A following full valid frame is processed correctly.
- Overrun and reset: inject rx byte during TX_RES -> rx_overrun pulse, reply intact. Assert rst=0 mid-RX_DATA -> all outputs 0 asynchronously, and the next frame after release is decoded from its command byte.
